pri_irq_ctrl: RTL and testbench

- Parametrised, registered successor to the team's combinational 8:3 priority encoder.
- Edge-captures N request lines into a pending register and applies a per-bit mask.
- Offers the highest-priority pending index on a valid/ready handshake and clears that bit on acceptance.
- Sits between raw event sources (interrupts, DMA requests) and a single consumer that services one index at a time.

---
 rtl/pri_irq_pkg.sv | 14 +
 rtl/pri_enc_n.sv | 32 +++
 rtl/pri_irq_ctrl.sv | 145 ++++++++++++++
 tb/tb_pri_irq_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pri_irq_pkg.sv
// Shared types and helpers for the registered priority interrupt controller.
// Optional rotating priority is selected with the PRI_IRQ_RR_EN macro.
package pri_irq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pri_enc_n.sv
// Rotating N-to-IDX_W priority encoder: highest set bit of vec rotated by base.
// With base=0 this is a plain highest-index-wins encoder.
module pri_enc_n #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] base,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] hi;
  logic [IDX_W:0]   sum;

  always_comb begin
    // rot[j] = vec[(j+base) mod N], so rot[N-1] maps to vec[base-1]
    dbl = {vec, vec} >> base;
    rot = dbl[N-1:0];
    any = |vec;
    hi  = '0;
    for (int j = 0; j < N; j++) begin
      if (rot[j]) hi = IDX_W'(j);
    end
    sum = {1'b0, hi} + {1'b0, base};
    if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/pri_irq_ctrl.sv
// Edge-capturing masked priority controller with a valid/ready offer port.
// Define PRI_IRQ_RR_EN for rotating priority; default is fixed highest-index.
module pri_irq_ctrl
  import pri_irq_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  input  logic             clr_all,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic             out_en,
  output logic [N-1:0]     pend,
  output logic             ovf
);

  state_e           state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     req_q;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             en_q, en_d;
  logic             ovf_q, ovf_d;

  logic [N-1:0]     rise;
  logic [N-1:0]     clr;
  logic [N-1:0]     elig;
  logic             accept;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic [IDX_W-1:0] base;

`ifdef PRI_IRQ_RR_EN
  logic [IDX_W-1:0] lptr_q, lptr_d;

  always_comb begin
    lptr_d = lptr_q;
    if (accept && !clr_all) lptr_d = idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lptr_q <= '0;
    else     lptr_q <= lptr_d;
  end

  assign base = lptr_q;
`else
  assign base = '0;
`endif

  assign rise   = req_in & ~req_q;
  assign accept = (state_q == OFFER) && out_ready;
  assign clr    = accept ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;
  assign elig   = pend_q & ~mask;

  pri_enc_n #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec  (elig),
    .base (base),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  // A rise on the bit being cleared re-arms it instead of being lost
  always_comb begin
    pend_d = (pend_q & ~clr) | rise;
    ovf_d  = ovf_q | (|(rise & pend_q & ~clr));
    if (clr_all) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end
    en_d = |(pend_d & ~mask);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enc_any)   state_d = OFFER;
      OFFER:   if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    if (clr_all) state_d = IDLE;
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (enc_any) begin
          valid_d = 1'b1;
          idx_d   = enc_idx;
        end
      end
      OFFER: begin
        if (out_ready) begin
          valid_d = 1'b0;
          idx_d   = '0;
        end
      end
      default: begin
        valid_d = 1'b0;
        idx_d   = '0;
      end
    endcase
    if (clr_all) begin
      valid_d = 1'b0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      req_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      req_q   <= req_in;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_en    = en_q;
  assign pend      = pend_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pri_irq_ctrl.sv
// Directed bench for pri_irq_ctrl; expected grant order follows PRI_IRQ_RR_EN.
module tb_pri_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       clr_all;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_ready;
  logic       out_en;
  logic [7:0] pend;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int g;
  logic [2:0] exp6 [4];
  logic [2:0] e;

  always #5 clk = ~clk;

  pri_irq_ctrl #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask      (mask),
    .clr_all   (clr_all),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .out_en    (out_en),
    .pend      (pend),
    .ovf       (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef PRI_IRQ_RR_EN
    exp6[0] = 3'd3; exp6[1] = 3'd1; exp6[2] = 3'd3; exp6[3] = 3'd1;
`else
    exp6[0] = 3'd3; exp6[1] = 3'd3; exp6[2] = 3'd3; exp6[3] = 3'd3;
`endif
    rst = 1'b1; req_in = '0; mask = '0; clr_all = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_pend", pend, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_idx", out_idx, 3'd0);
    chk("rst_en", out_en, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    // 1: two requests, fixed order 5 then 2
    req_in = 8'h24; out_ready = 1'b1;
    tick(); req_in = 8'h00;
    chk("t1_pend", pend, 8'h24);
    chk("t1_valid0", out_valid, 1'b0);
    chk("t1_en", out_en, 1'b1);
    tick();
    chk("t1_valid5", out_valid, 1'b1);
    chk("t1_idx5", out_idx, 3'd5);
    tick();
    chk("t1_acc_valid", out_valid, 1'b0);
    chk("t1_acc_pend", pend, 8'h04);
    tick();
    chk("t1_valid2", out_valid, 1'b1);
    chk("t1_idx2", out_idx, 3'd2);
    tick();
    chk("t1_pend0", pend, 8'h00);
    chk("t1_ovf", ovf, 1'b0);
    chk("t1_en0", out_en, 1'b0);

    // 2: masked top bit, stalled offer
    out_ready = 1'b0; mask = 8'h80; req_in = 8'hC0;
    tick(); req_in = 8'h00;
    chk("t2_pend", pend, 8'hC0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", out_valid, 1'b1);
      chk("t2_hold_idx", out_idx, 3'd6);
      chk("t2_hold_en", out_en, 1'b1);
      tick();
    end
    mask = 8'h00; out_ready = 1'b1;
    tick();
    chk("t2_acc_valid", out_valid, 1'b0);
    chk("t2_acc_pend", pend, 8'h80);
    tick();
    chk("t2_idx7", out_idx, 3'd7);
    chk("t2_valid7", out_valid, 1'b1);
    tick();
    chk("t2_pend0", pend, 8'h00);
    out_ready = 1'b0;

    // 3: re-pulse on accept re-arms, re-pulse while pending overflows
    req_in = 8'h08;
    tick(); req_in = 8'h00;
    tick();
    chk("t3_idx3", out_idx, 3'd3);
    out_ready = 1'b1; req_in = 8'h08;
    tick(); req_in = 8'h00; out_ready = 1'b0;
    chk("t3_rearm_pend", pend, 8'h08);
    chk("t3_rearm_ovf", ovf, 1'b0);
    chk("t3_rearm_valid", out_valid, 1'b0);
    tick();
    chk("t3_reoffer_valid", out_valid, 1'b1);
    chk("t3_reoffer_idx", out_idx, 3'd3);
    req_in = 8'h08;
    tick(); req_in = 8'h00;
    chk("t3_ovf", ovf, 1'b1);
    chk("t3_ovf_pend", pend, 8'h08);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    chk("t3_acc_pend", pend, 8'h00);
    chk("t3_ovf_sticky", ovf, 1'b1);
    clr_all = 1'b1;
    tick(); clr_all = 1'b0;
    chk("t3_ovf_clr", ovf, 1'b0);

    // 4: all lines held high across reset release
    rst = 1'b1; req_in = 8'hFF;
    tick(); tick();
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("t4_pend", pend, 8'hFF);
    g = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) begin
        e = 3'(7 - g);
        chk("t4_order", out_idx, e);
        g++;
      end
    end
    chk("t4_grants", g, 8);
    chk("t4_pend0", pend, 8'h00);
    chk("t4_ovf", ovf, 1'b0);
    req_in = 8'h00; out_ready = 1'b0;
    tick();

    // 5: clr_all during an offer drops state and same-cycle rises
    req_in = 8'h11;
    tick(); req_in = 8'h00;
    tick();
    chk("t5_idx4", out_idx, 3'd4);
    req_in = 8'h01;
    tick(); req_in = 8'h00;
    chk("t5_ovf1", ovf, 1'b1);
    tick();
    clr_all = 1'b1; req_in = 8'h02;
    tick(); clr_all = 1'b0;
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_idx", out_idx, 3'd0);
    chk("t5_pend", pend, 8'h00);
    chk("t5_ovf", ovf, 1'b0);
    chk("t5_en", out_en, 1'b0);
    tick();
    chk("t5_held_nofire", pend, 8'h00);
    chk("t5_held_valid", out_valid, 1'b0);
    req_in = 8'h00;
    tick();

    // 6: re-pulse each granted bit so pend stays 8'h0A
    req_in = 8'h0A;
    tick(); req_in = 8'h00;
    chk("t6_pend", pend, 8'h0A);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_valid", out_valid, 1'b1);
      chk("t6_order", out_idx, exp6[k]);
      req_in = 8'h01 << exp6[k];
      tick(); req_in = 8'h00;
      chk("t6_pend_kept", pend, 8'h0A);
    end
    out_ready = 1'b0;
    clr_all = 1'b1;
    tick(); clr_all = 1'b0;
    chk("t6_clr", pend, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
